// File: rtl/twiddle_sched_pkg.sv
// rtl/twiddle_sched_pkg.sv - shared types, constants and butterfly address function
package twiddle_sched_pkg;

    localparam int STAGE_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_MULT,
        ST_WAIT,
        ST_WRITE,
        ST_NEXT,
        ST_DONE
    } state_t;

    // Wide enough for the largest legal FFT (N_LOG2 = 8); callers slice down.
    typedef struct packed {
        logic [7:0] addr_a;
        logic [7:0] addr_b;
        logic [7:0] tw_addr;
    } bfly_addr_t;

    // Radix-2 DIT butterfly j of stage s: pairs are 'half' apart inside
    // groups of 2*half, twiddle stride shrinks as the stage grows.
    function automatic bfly_addr_t bfly_addr(input int n_log2,
                                             input logic [STAGE_W-1:0] s,
                                             input logic [7:0] j);
        bfly_addr_t r;
        logic [7:0] half;
        logic [7:0] pos;
        logic [7:0] grp;
        half      = 8'd1 << s;
        pos       = j & (half - 8'd1);
        grp       = j >> s;
        r.addr_a  = ((grp << s) << 1) + pos;
        r.addr_b  = r.addr_a + half;
        r.tw_addr = pos << (n_log2 - 1 - int'(s));
        return r;
    endfunction

endpackage

// File: rtl/twiddle_sched_if.sv
// rtl/twiddle_sched_if.sv - control/address bus between FFT control and twiddle_sched
// master: FFT control side (drives i_go, i_mult_done); slave: twiddle_sched.
interface twiddle_sched_if #(
    parameter int N_LOG2 = 3
);
    import twiddle_sched_pkg::*;

    logic               i_go;
    logic               i_mult_done;
    logic               o_busy;
    logic               o_done;
    logic               o_rd_en;
    logic               o_mult_start;
    logic               o_wr_en;
    logic [N_LOG2-1:0]  o_addr_a;
    logic [N_LOG2-1:0]  o_addr_b;
    logic [N_LOG2-2:0]  o_tw_addr;
    logic [STAGE_W-1:0] o_stage;
    logic               o_err;

    modport master (
        output i_go, i_mult_done,
        input  o_busy, o_done, o_rd_en, o_mult_start, o_wr_en,
        input  o_addr_a, o_addr_b, o_tw_addr, o_stage, o_err
    );

    modport slave (
        input  i_go, i_mult_done,
        output o_busy, o_done, o_rd_en, o_mult_start, o_wr_en,
        output o_addr_a, o_addr_b, o_tw_addr, o_stage, o_err
    );

endinterface

// File: rtl/twiddle_addr_gen.sv
// rtl/twiddle_addr_gen.sv - combinational (stage, butterfly) to sample/twiddle addresses
// i_stage, i_bfly in; o_addr_a, o_addr_b, o_tw_addr out (unregistered).
module twiddle_addr_gen
    import twiddle_sched_pkg::*;
#(
    parameter int N_LOG2 = 3
) (
    input  logic [STAGE_W-1:0] i_stage,
    input  logic [N_LOG2-2:0]  i_bfly,
    output logic [N_LOG2-1:0]  o_addr_a,
    output logic [N_LOG2-1:0]  o_addr_b,
    output logic [N_LOG2-2:0]  o_tw_addr
);

    bfly_addr_t w_addr;
    logic       w_unused;

    assign w_addr    = bfly_addr(N_LOG2, i_stage, 8'(i_bfly));
    assign o_addr_a  = w_addr.addr_a[N_LOG2-1:0];
    assign o_addr_b  = w_addr.addr_b[N_LOG2-1:0];
    assign o_tw_addr = w_addr.tw_addr[N_LOG2-2:0];

    // Upper bits are always zero for N_LOG2 < 8.
    assign w_unused  = ^w_addr;

endmodule

// File: rtl/twiddle_sched.sv
// rtl/twiddle_sched.sv - radix-2 DIT FFT pass sequencer for one twiddle_mult
// clk, rst_n (async, active-low); bus: twiddle_sched_if.slave (i_go, i_mult_done in;
// busy/done/strobes/addresses/stage/err out). Optional watchdog: TWIDDLE_SCHED_TIMEOUT_EN.
module twiddle_sched
    import twiddle_sched_pkg::*;
#(
    parameter int N_LOG2      = 3,
    parameter int TIMEOUT_CYC = 63
) (
    input  logic           clk,
    input  logic           rst_n,
    twiddle_sched_if.slave bus
);

    localparam int BFLY_W = N_LOG2 - 1;

    state_t             r_state;
    logic [STAGE_W-1:0] r_s;
    logic [BFLY_W-1:0]  r_j;
    logic               r_busy;
    logic               r_done;
    logic               r_rd_en;
    logic               r_mult_start;
    logic               r_wr_en;
    logic [N_LOG2-1:0]  r_addr_a;
    logic [N_LOG2-1:0]  r_addr_b;
    logic [BFLY_W-1:0]  r_tw_addr;

    logic               w_last_j;
    logic               w_last_s;
    logic [STAGE_W-1:0] w_s_nxt;
    logic [BFLY_W-1:0]  w_j_nxt;
    logic [N_LOG2-1:0]  w_addr_a;
    logic [N_LOG2-1:0]  w_addr_b;
    logic [BFLY_W-1:0]  w_tw_addr;

`ifdef TWIDDLE_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_err;
    assign bus.o_err = r_err;
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;
    assign bus.o_err = 1'b0;
`endif

    assign w_last_j = &r_j;
    assign w_last_s = (r_s == STAGE_W'(N_LOG2 - 1));

    // Counters the next READ will use; zero when starting from IDLE.
    always_comb begin
        w_s_nxt = '0;
        w_j_nxt = '0;
        if (r_state == ST_NEXT) begin
            if (w_last_j) begin
                w_s_nxt = r_s + STAGE_W'(1);
            end else begin
                w_s_nxt = r_s;
                w_j_nxt = r_j + BFLY_W'(1);
            end
        end
    end

    twiddle_addr_gen #(.N_LOG2(N_LOG2)) u_addr_gen (
        .i_stage   (w_s_nxt),
        .i_bfly    (w_j_nxt),
        .o_addr_a  (w_addr_a),
        .o_addr_b  (w_addr_b),
        .o_tw_addr (w_tw_addr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_s          <= '0;
            r_j          <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_rd_en      <= 1'b0;
            r_mult_start <= 1'b0;
            r_wr_en      <= 1'b0;
            r_addr_a     <= '0;
            r_addr_b     <= '0;
            r_tw_addr    <= '0;
`ifdef TWIDDLE_SCHED_TIMEOUT_EN
            r_wait_cnt   <= '0;
            r_err        <= 1'b0;
`endif
        end else begin
            r_done       <= 1'b0;
            r_rd_en      <= 1'b0;
            r_mult_start <= 1'b0;
            r_wr_en      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.i_go) begin
                        r_state   <= ST_READ;
                        r_s       <= '0;
                        r_j       <= '0;
                        r_busy    <= 1'b1;
                        r_rd_en   <= 1'b1;
                        r_addr_a  <= w_addr_a;
                        r_addr_b  <= w_addr_b;
                        r_tw_addr <= w_tw_addr;
                    end
                end
                ST_READ: begin
                    r_state      <= ST_MULT;
                    r_mult_start <= 1'b1;
                end
                ST_MULT: begin
                    r_state    <= ST_WAIT;
`ifdef TWIDDLE_SCHED_TIMEOUT_EN
                    r_wait_cnt <= '0;
`endif
                end
                ST_WAIT: begin
                    if (bus.i_mult_done) begin
                        r_state <= ST_WRITE;
                        r_wr_en <= 1'b1;
                    end
`ifdef TWIDDLE_SCHED_TIMEOUT_EN
                    // Abandon the pass silently; only o_err records it.
                    else if (r_wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_err   <= 1'b1;
                        r_s     <= '0;
                        r_j     <= '0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end
`endif
                end
                ST_WRITE: begin
                    r_state <= ST_NEXT;
                end
                ST_NEXT: begin
                    if (w_last_j && w_last_s) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state   <= ST_READ;
                        r_s       <= w_s_nxt;
                        r_j       <= w_j_nxt;
                        r_rd_en   <= 1'b1;
                        r_addr_a  <= w_addr_a;
                        r_addr_b  <= w_addr_b;
                        r_tw_addr <= w_tw_addr;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_busy       = r_busy;
    assign bus.o_done       = r_done;
    assign bus.o_rd_en      = r_rd_en;
    assign bus.o_mult_start = r_mult_start;
    assign bus.o_wr_en      = r_wr_en;
    assign bus.o_addr_a     = r_addr_a;
    assign bus.o_addr_b     = r_addr_b;
    assign bus.o_tw_addr    = r_tw_addr;
    assign bus.o_stage      = r_s;

endmodule
